decoder_mac_seq: RTL and testbench

DECODER_MAC_SEQ -- requirements
Module: decoder_mac_seq

---
 rtl/decoder_pkg.sv | 19 +
 rtl/decoder_mac_lane.sv | 82 ++++++++
 rtl/decoder_mac_seq.sv | 132 +++++++++++++
 tb/tb_decoder_mac_seq.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared definitions for the decoder MAC sequencer: FSM encoding, default
// word geometry and the saturation limits for the default word width.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        BIAS = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_BITSIZE    = 32;
    localparam int DEF_FRAC_BITS  = 16;
    localparam int DEF_GUARD_BITS = 8;

    localparam logic [DEF_BITSIZE-1:0] SAT_MAX = {1'b0, {(DEF_BITSIZE-1){1'b1}}};
    localparam logic [DEF_BITSIZE-1:0] SAT_MIN = {1'b1, {(DEF_BITSIZE-1){1'b0}}};

endpackage

// File: rtl/decoder_mac_lane.sv
// One output neuron: fixed-point multiply, arithmetic shift, accumulate and
// bias add. Define DECODER_SAT_EN to clip the result instead of wrapping it.
module decoder_mac_lane
    import decoder_pkg::*;
#(
    parameter int BITSIZE    = DEF_BITSIZE,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter int GUARD_BITS = DEF_GUARD_BITS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_mac,
    input  logic               i_bias,
    input  logic [BITSIZE-1:0] i_z,
    input  logic [BITSIZE-1:0] i_w,
    input  logic [BITSIZE-1:0] i_b,
    output logic [BITSIZE-1:0] o_out,
    output logic               o_sat
);

    localparam int ACCW = BITSIZE + GUARD_BITS;
    localparam int PW   = (2*BITSIZE > ACCW) ? 2*BITSIZE : ACCW;

    logic signed [2*BITSIZE-1:0] w_prod;
    logic signed [2*BITSIZE-1:0] w_shift;
    logic signed [PW-1:0]        w_ext;
    logic signed [ACCW-1:0]      w_term;
    logic signed [ACCW-1:0]      w_sum;
    logic        [BITSIZE-1:0]   w_res;
    logic                        w_clip;
    logic signed [ACCW-1:0]      r_acc;
    logic        [BITSIZE-1:0]   r_out;
    logic                        r_sat;

    // Full-width signed product; the shift floors toward minus infinity.
    assign w_prod  = $signed({{BITSIZE{i_z[BITSIZE-1]}}, i_z}) *
                     $signed({{BITSIZE{i_w[BITSIZE-1]}}, i_w});
    assign w_shift = w_prod >>> FRAC_BITS;
    assign w_ext   = PW'(w_shift);
    assign w_term  = w_ext[ACCW-1:0];
    assign w_sum   = r_acc + ACCW'(signed'(i_b));

`ifdef DECODER_SAT_EN
    localparam logic [BITSIZE-1:0] LIM_MAX = {1'b0, {(BITSIZE-1){1'b1}}};
    localparam logic [BITSIZE-1:0] LIM_MIN = {1'b1, {(BITSIZE-1){1'b0}}};

    // The sum fits when every bit above the result's sign bit copies it.
    always_comb begin
        w_clip = ~((&w_sum[ACCW-1:BITSIZE-1]) | ~(|w_sum[ACCW-1:BITSIZE-1]));
        w_res  = w_sum[BITSIZE-1:0];
        if (w_clip) begin
            w_res = w_sum[ACCW-1] ? LIM_MIN : LIM_MAX;
        end
    end
`else
    assign w_clip = 1'b0;
    assign w_res  = w_sum[BITSIZE-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_out <= '0;
            r_sat <= 1'b0;
        end else begin
            if (i_clear) begin
                r_acc <= '0;
            end else if (i_mac) begin
                r_acc <= r_acc + w_term;
            end
            if (i_bias) begin
                r_out <= w_res;
                r_sat <= w_clip;
            end
        end
    end

    assign o_out = r_out;
    assign o_sat = r_sat;

endmodule

// File: rtl/decoder_mac_seq.sv
// Sequential dense layer: one MAC step per clock across all output lanes,
// then a bias step and a held result. Macro DECODER_SAT_EN enables clipping.
module decoder_mac_seq
    import decoder_pkg::*;
#(
    parameter int N_INPUT    = 2,
    parameter int M_OUTPUT   = 9,
    parameter int BITSIZE    = DEF_BITSIZE,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter int GUARD_BITS = DEF_GUARD_BITS
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [N_INPUT*BITSIZE-1:0]          z,
    input  logic [N_INPUT*M_OUTPUT*BITSIZE-1:0] w,
    input  logic [M_OUTPUT*BITSIZE-1:0]         b,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [M_OUTPUT*BITSIZE-1:0]     out,
    output logic                            sat_flag
);

    localparam int KW = (N_INPUT > 1) ? $clog2(N_INPUT) : 1;

    state_t                            r_state;
    state_t                            w_next;
    logic                              w_accept;
    logic                              w_mac;
    logic                              w_bias;
    logic                              w_lastK;
    logic [KW-1:0]                     r_k;
    logic                              r_outValid;
    logic [N_INPUT*BITSIZE-1:0]          r_z;
    logic [N_INPUT*M_OUTPUT*BITSIZE-1:0] r_w;
    logic [M_OUTPUT*BITSIZE-1:0]         r_b;
    logic [BITSIZE-1:0]                w_zSel;
    logic [M_OUTPUT-1:0]               w_laneSat;

    assign w_lastK = (r_k == KW'(N_INPUT-1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_mac    = 1'b0;
        w_bias   = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = ACC;
                end
            end
            ACC: begin
                w_mac = 1'b1;
                if (w_lastK) begin
                    w_next = BIAS;
                end
            end
            BIAS: begin
                w_bias = 1'b1;
                w_next = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Operands are captured at acceptance so later input changes cannot leak in.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k        <= '0;
            r_outValid <= 1'b0;
            r_z        <= '0;
            r_w        <= '0;
            r_b        <= '0;
        end else begin
            if (w_accept) begin
                r_z <= z;
                r_w <= w;
                r_b <= b;
                r_k <= '0;
            end else if (w_mac) begin
                r_k <= w_lastK ? '0 : r_k + KW'(1);
            end
            if (w_bias) begin
                r_outValid <= 1'b1;
            end else if ((r_state == DONE) && out_ready) begin
                r_outValid <= 1'b0;
            end
        end
    end

    assign w_zSel = r_z[int'(r_k)*BITSIZE +: BITSIZE];

    for (genvar j = 0; j < M_OUTPUT; j++) begin : gLane
        decoder_mac_lane #(
            .BITSIZE   (BITSIZE),
            .FRAC_BITS (FRAC_BITS),
            .GUARD_BITS(GUARD_BITS)
        ) uLane (
            .clk    (clk),
            .rst    (rst),
            .i_clear(w_accept),
            .i_mac  (w_mac),
            .i_bias (w_bias),
            .i_z    (w_zSel),
            .i_w    (r_w[(j*N_INPUT + int'(r_k))*BITSIZE +: BITSIZE]),
            .i_b    (r_b[j*BITSIZE +: BITSIZE]),
            .o_out  (out[j*BITSIZE +: BITSIZE]),
            .o_sat  (w_laneSat[j])
        );
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_outValid;
    assign sat_flag  = |w_laneSat;

endmodule

// File: tb/tb_decoder_mac_seq.sv
// Directed bench for decoder_mac_seq: a default-geometry instance and an
// N=3 instance with wide guard bits so the clipping case has a true positive sum.
module tb_decoder_mac_seq;

    localparam int BS = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic            v2 = 1'b0;
    logic            rdy2;
    logic            ov2;
    logic            ordy2 = 1'b0;
    logic            sat2;
    logic [2*BS-1:0]  z2 = '0;
    logic [18*BS-1:0] w2 = '0;
    logic [9*BS-1:0]  b2 = '0;
    logic [9*BS-1:0]  out2;

    logic            v3 = 1'b0;
    logic            rdy3;
    logic            ov3;
    logic            ordy3 = 1'b0;
    logic            sat3;
    logic [3*BS-1:0] z3 = '0;
    logic [6*BS-1:0] w3 = '0;
    logic [2*BS-1:0] b3 = '0;
    logic [2*BS-1:0] out3;

    int checks = 0;
    int errors = 0;

    decoder_mac_seq #(.N_INPUT(2), .M_OUTPUT(9)) d2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2),
        .z(z2), .w(w2), .b(b2), .out_valid(ov2), .out_ready(ordy2),
        .out(out2), .sat_flag(sat2)
    );

    decoder_mac_seq #(.N_INPUT(3), .M_OUTPUT(2), .GUARD_BITS(16)) d3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_ready(rdy3),
        .z(z3), .w(w3), .b(b3), .out_valid(ov3), .out_ready(ordy3),
        .out(out3), .sat_flag(sat3)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    // Present one job, scramble the inputs after acceptance, count edges to out_valid.
    task automatic applyStimulus2(input logic [2*BS-1:0] z, input logic [18*BS-1:0] w,
                                  input logic [9*BS-1:0] b, output int lat);
        @(negedge clk);
        z2 = z; w2 = w; b2 = b; v2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v2 = 1'b0; z2 = '1; w2 = '1; b2 = '1;
        lat = 0;
        while (!ov2 && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic applyStimulus3(input logic [3*BS-1:0] z, input logic [6*BS-1:0] w,
                                  input logic [2*BS-1:0] b, output int lat);
        @(negedge clk);
        z3 = z; w3 = w; b3 = b; v3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v3 = 1'b0; z3 = '1; w3 = '1; b3 = '1;
        lat = 0;
        while (!ov3 && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic releaseOutput2();
        ordy2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy2 = 1'b0;
    endtask

    task automatic releaseOutput3();
        ordy3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy3 = 1'b0;
    endtask

    initial begin
        int lat;
        logic [18*BS-1:0] wv2;
        logic [9*BS-1:0]  bv2;
        logic [6*BS-1:0]  wv3;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rstReady2", 32'(rdy2), 32'd1);
        checkOutput("rstValid2", 32'(ov2), 32'd0);
        checkOutput("rstOut2", out2[31:0], 32'h0);
        checkOutput("rstSat2", 32'(sat2), 32'd0);
        checkOutput("rstReady3", 32'(rdy3), 32'd1);

        // 1.0*0.5 + 2.0*0.5 + 0.25 = 1.75 on every lane
        for (int i = 0; i < 18; i++) wv2[i*BS +: BS] = 32'h00008000;
        for (int j = 0; j < 9; j++) bv2[j*BS +: BS] = 32'h00004000;
        applyStimulus2({32'h00020000, 32'h00010000}, wv2, bv2, lat);
        checkOutput("basicLatency", 32'(lat), 32'd3);
        for (int j = 0; j < 9; j++) begin
            checkOutput($sformatf("basicLane%0d", j), out2[j*BS +: BS], 32'h0001C000);
        end
        checkOutput("basicSat", 32'(sat2), 32'd0);

        v2 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("holdValid%0d", c), 32'(ov2), 32'd1);
            checkOutput($sformatf("holdReady%0d", c), 32'(rdy2), 32'd0);
            checkOutput($sformatf("holdOut%0d", c), out2[31:0], 32'h0001C000);
        end
        v2 = 1'b0;
        releaseOutput2();
        checkOutput("releaseValid", 32'(ov2), 32'd0);
        checkOutput("releaseReady", 32'(rdy2), 32'd1);
        checkOutput("releaseOut", out2[31:0], 32'h0001C000);

        // -0.5 * 2^-16 floors to -2^-16
        for (int i = 0; i < 18; i++) wv2[i*BS +: BS] = 32'h00000001;
        applyStimulus2({32'h00000000, 32'hFFFF8000}, wv2, '0, lat);
        checkOutput("floorLatency", 32'(lat), 32'd3);
        checkOutput("floorLane0", out2[31:0], 32'hFFFFFFFF);
        checkOutput("floorLane8", out2[8*BS +: BS], 32'hFFFFFFFF);
        releaseOutput2();

        // Reset while the k=1 step is pending, then a clean job
        for (int i = 0; i < 18; i++) wv2[i*BS +: BS] = 32'h00010000;
        @(negedge clk);
        z2 = {32'h00030000, 32'h00030000}; w2 = wv2; b2 = '0; v2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v2 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abortValid", 32'(ov2), 32'd0);
        checkOutput("abortOut", out2[31:0], 32'h0);
        checkOutput("abortReady", 32'(rdy2), 32'd1);
        applyStimulus2({32'h00010000, 32'h00010000}, wv2, '0, lat);
        checkOutput("afterAbortLatency", 32'(lat), 32'd3);
        checkOutput("afterAbortLane0", out2[31:0], 32'h00020000);
        checkOutput("afterAbortLane8", out2[8*BS +: BS], 32'h00020000);
        releaseOutput2();

        // lane0: 1*2 - 1*1 + 0.5*4 = 3.0; lane1: 0.5 - 0.5 + 0.25 + 1.0 = 1.25
        wv3 = {32'h00008000, 32'h00008000, 32'h00008000,
               32'h00040000, 32'h00010000, 32'h00020000};
        applyStimulus3({32'h00008000, 32'hFFFF0000, 32'h00010000}, wv3,
                       {32'h00010000, 32'h00000000}, lat);
        checkOutput("n3Latency", 32'(lat), 32'd4);
        checkOutput("n3Lane0", out3[31:0], 32'h00030000);
        checkOutput("n3Lane1", out3[63:32], 32'h00014000);
        releaseOutput3();

        // Exact sum 0x7FFE_0002_0000 in Q16.16 raw units
        for (int i = 0; i < 6; i++) wv3[i*BS +: BS] = 32'h7FFF0000;
        applyStimulus3({32'h00000000, 32'h7FFF0000, 32'h7FFF0000}, wv3, '0, lat);
        checkOutput("bigLatency", 32'(lat), 32'd4);
`ifdef DECODER_SAT_EN
        checkOutput("bigLane0", out3[31:0], 32'h7FFFFFFF);
        checkOutput("bigLane1", out3[63:32], 32'h7FFFFFFF);
        checkOutput("bigSat", 32'(sat3), 32'd1);
`else
        checkOutput("bigLane0", out3[31:0], 32'h00020000);
        checkOutput("bigLane1", out3[63:32], 32'h00020000);
        checkOutput("bigSat", 32'(sat3), 32'd0);
`endif
        releaseOutput3();
        checkOutput("finalReady3", 32'(rdy3), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
